// File: rtl/fb_swap_if.sv
// Framebuffer swap handshake between the render side, the display timing and the swap controller.
// The master drives the request and vsync pulses; the slave owns the buffer addresses and status.
interface fb_swap_if #(
  parameter int ADDR_WIDTH = 25
);
  logic                  swap_fb;
  logic                  fb_swapped;
  logic [ADDR_WIDTH-1:0] render_addr;
  logic                  vsync;
  logic [ADDR_WIDTH-1:0] disp_addr;
  logic                  swap_pending;
  logic [15:0]           frame_drop_cnt;

  modport master (
    output swap_fb,
    output vsync,
    input  fb_swapped,
    input  render_addr,
    input  disp_addr,
    input  swap_pending,
    input  frame_drop_cnt
  );

  modport slave (
    input  swap_fb,
    input  vsync,
    output fb_swapped,
    output render_addr,
    output disp_addr,
    output swap_pending,
    output frame_drop_cnt
  );
endinterface

// File: rtl/fb_swap_controller.sv
// Framebuffer ownership/swap controller: double or triple buffering, vsync-locked or immediate
// commits, optional mailbox frame dropping. All outputs are registered.
module fb_swap_controller #(
  parameter int          ADDR_WIDTH   = 25,
  parameter int          FB_COUNT     = 2,
  parameter int unsigned FB_BASE_ADDR = 32'h0010_0000,
  parameter int unsigned FB_STRIDE    = 32'h0004_0000,
  parameter bit          VSYNC_WAIT   = 1'b1,
  parameter bit          DROP_FRAMES  = 1'b1
) (
  input  logic       aclk,
  input  logic       rst,
  fb_swap_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    WAIT_VSYNC = 1'b1
  } state_t;

  localparam bit TRIPLE   = (FB_COUNT == 3);
  // Without vsync locking a triple-buffered swap can never stall, so it always overwrites.
  localparam bit EFF_DROP = DROP_FRAMES || !VSYNC_WAIT;

  function automatic logic [ADDR_WIDTH-1:0] fb_addr(input logic [1:0] idx);
    logic [63:0] a;
    a = 64'(FB_BASE_ADDR) + (64'(idx) * 64'(FB_STRIDE));
    return a[ADDR_WIDTH-1:0];
  endfunction

  state_t                state_r, state_s;
  logic [1:0]            render_idx_r, render_idx_s;
  logic [1:0]            disp_idx_r, disp_idx_s;
  logic [1:0]            ready_idx_r, ready_idx_s;
  logic                  ready_vld_r, ready_vld_s;
  logic                  stall_s;
  logic                  swap_req_s;
  logic                  commit_s;
  logic                  drop_s;
  logic [ADDR_WIDTH-1:0] render_addr_r, disp_addr_r;
  logic                  fb_swapped_r, swap_pending_r;
  logic [15:0]           drop_cnt_r;

  // A request that arrives in IDLE but cannot be committed this cycle.
  always_comb begin
    stall_s = 1'b0;
    if (TRIPLE) begin
      stall_s = ready_vld_r && !bus.vsync && !EFF_DROP;
    end else begin
      stall_s = VSYNC_WAIT && !bus.vsync;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.swap_fb && stall_s) begin
          state_s = WAIT_VSYNC;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_VSYNC: begin
        if (bus.vsync) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_VSYNC;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM output logic: buffer role updates, commit and drop events.
  always_comb begin
    render_idx_s = render_idx_r;
    disp_idx_s   = disp_idx_r;
    ready_idx_s  = ready_idx_r;
    ready_vld_s  = ready_vld_r;
    commit_s     = 1'b0;
    drop_s       = 1'b0;
    swap_req_s   = ((state_r == IDLE) && bus.swap_fb && !stall_s) ||
                   ((state_r == WAIT_VSYNC) && bus.vsync);
    if (TRIPLE) begin
      // The display advance is evaluated first so a same-cycle swap sees the freed buffer.
      if (bus.vsync && ready_vld_r) begin
        disp_idx_s  = ready_idx_r;
        ready_vld_s = 1'b0;
      end else begin
        disp_idx_s  = disp_idx_r;
        ready_vld_s = ready_vld_r;
      end
      if (swap_req_s) begin
        commit_s    = 1'b1;
        ready_idx_s = render_idx_r;
        if (!ready_vld_s) begin
          // Indices 0+1+2 sum to 3, so the free buffer is whatever render and display leave over.
          render_idx_s = 2'd3 - render_idx_r - disp_idx_s;
          ready_vld_s  = 1'b1;
        end else begin
          render_idx_s = ready_idx_r;
          drop_s       = 1'b1;
        end
      end else begin
        commit_s = 1'b0;
      end
    end else begin
      if (swap_req_s) begin
        render_idx_s = disp_idx_r;
        disp_idx_s   = render_idx_r;
        commit_s     = 1'b1;
      end else begin
        commit_s = 1'b0;
      end
    end
  end

  // Buffer role registers and registered outputs.
  always_ff @(posedge aclk) begin
    if (rst) begin
      render_idx_r   <= 2'd0;
      disp_idx_r     <= 2'(FB_COUNT - 1);
      ready_idx_r    <= 2'd0;
      ready_vld_r    <= 1'b0;
      render_addr_r  <= fb_addr(2'd0);
      disp_addr_r    <= fb_addr(2'(FB_COUNT - 1));
      fb_swapped_r   <= 1'b0;
      swap_pending_r <= 1'b0;
      drop_cnt_r     <= 16'd0;
    end else begin
      render_idx_r   <= render_idx_s;
      disp_idx_r     <= disp_idx_s;
      ready_idx_r    <= ready_idx_s;
      ready_vld_r    <= ready_vld_s;
      render_addr_r  <= fb_addr(render_idx_s);
      disp_addr_r    <= fb_addr(disp_idx_s);
      fb_swapped_r   <= commit_s;
      swap_pending_r <= (state_s == WAIT_VSYNC);
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign bus.render_addr    = render_addr_r;
  assign bus.disp_addr      = disp_addr_r;
  assign bus.fb_swapped     = fb_swapped_r;
  assign bus.swap_pending   = swap_pending_r;
  assign bus.frame_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Randomized and directed bench for fb_swap_controller over five configurations sharing one stimulus.
// A role-based reference model (render/display/ready/free buffers) predicts every output each cycle.
module tb_fb_swap_controller;

  localparam int NM = 5;

  logic aclk;
  logic rst;
  logic swap_fb;
  logic vsync;

  logic [24:0] ra_o [NM];
  logic [24:0] da_o [NM];
  logic        sw_o [NM];
  logic        sp_o [NM];
  logic [15:0] dc_o [NM];

  int n_checks;
  int n_pass;

  // Configurations: 0 FB2 vsync, 1 FB2 immediate, 2 FB3 mailbox, 3 FB3 stall, 4 FB3 immediate.
  for (genvar g = 0; g < NM; g++) begin : g_dut
    fb_swap_if #(.ADDR_WIDTH(25)) bus ();
    assign bus.swap_fb = swap_fb;
    assign bus.vsync   = vsync;
    assign ra_o[g] = bus.render_addr;
    assign da_o[g] = bus.disp_addr;
    assign sw_o[g] = bus.fb_swapped;
    assign sp_o[g] = bus.swap_pending;
    assign dc_o[g] = bus.frame_drop_cnt;
    fb_swap_controller #(
      .ADDR_WIDTH  (25),
      .FB_COUNT    ((g < 2) ? 2 : 3),
      .VSYNC_WAIT  ((g == 1 || g == 4) ? 1'b0 : 1'b1),
      .DROP_FRAMES ((g == 3 || g == 4) ? 1'b0 : 1'b1)
    ) u_dut (
      .aclk (aclk),
      .rst  (rst),
      .bus  (bus)
    );
  end

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference model state, one entry per configuration; -1 means the role is unoccupied.
  int m_render [NM];
  int m_disp   [NM];
  int m_ready  [NM];
  bit m_pend   [NM];
  int m_cnt    [NM];
  bit m_swp    [NM];

  function automatic int cfg_fbc(int m);
    return (m < 2) ? 2 : 3;
  endfunction

  function automatic bit cfg_vw(int m);
    return !(m == 1 || m == 4);
  endfunction

  function automatic bit cfg_drop(int m);
    return !(m == 3 || m == 4);
  endfunction

  function automatic logic [24:0] exp_addr(int idx);
    return 25'(32'h0010_0000 + idx * 32'h0004_0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_free(int m);
    int f;
    f = -1;
    for (int i = 0; i < cfg_fbc(m); i++) begin
      if (i != m_render[m] && i != m_disp[m] && i != m_ready[m]) f = i;
    end
    return f;
  endfunction

  function automatic void model_reset(int m);
    m_render[m] = 0;
    m_disp[m]   = cfg_fbc(m) - 1;
    m_ready[m]  = -1;
    m_pend[m]   = 1'b0;
    m_cnt[m]    = 0;
    m_swp[m]    = 1'b0;
  endfunction

  function automatic void model_step(int m, bit sw, bit vs, bit rs);
    int t;
    bit do_swap;
    m_swp[m] = 1'b0;
    if (rs) begin
      model_reset(m);
    end else if (cfg_fbc(m) == 2) begin
      if (m_pend[m] ? vs : (sw && (vs || !cfg_vw(m)))) begin
        t = m_render[m]; m_render[m] = m_disp[m]; m_disp[m] = t;
        m_swp[m]  = 1'b1;
        m_pend[m] = 1'b0;
      end else if (!m_pend[m] && sw) begin
        m_pend[m] = 1'b1;
      end
    end else begin
      if (vs && m_ready[m] >= 0) begin
        m_disp[m]  = m_ready[m];
        m_ready[m] = -1;
      end
      do_swap = m_pend[m] ? vs : sw;
      if (m_pend[m] && vs) m_pend[m] = 1'b0;
      if (do_swap) begin
        if (m_ready[m] < 0) begin
          t = find_free(m);
          m_ready[m]  = m_render[m];
          m_render[m] = t;
          m_swp[m]    = 1'b1;
        end else if (cfg_drop(m) || !cfg_vw(m)) begin
          t = m_ready[m];
          m_ready[m]  = m_render[m];
          m_render[m] = t;
          m_swp[m]    = 1'b1;
          if (m_cnt[m] < 65535) m_cnt[m]++;
        end else begin
          m_pend[m] = 1'b1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("swapped%0d", m), sw_o[m], m_swp[m]);
      chk($sformatf("pending%0d", m), sp_o[m], m_pend[m]);
      chk($sformatf("render_addr%0d", m), ra_o[m], exp_addr(m_render[m]));
      chk($sformatf("disp_addr%0d", m), da_o[m], exp_addr(m_disp[m]));
      chk($sformatf("drop_cnt%0d", m), dc_o[m], m_cnt[m]);
      chk($sformatf("distinct%0d", m), (ra_o[m] != da_o[m]), 1'b1);
    end
  endtask

  task automatic cycle(input bit sw, input bit vs, input bit rs);
    @(negedge aclk);
    swap_fb = sw;
    vsync   = vs;
    rst     = rs;
    @(posedge aclk);
    #1;
    for (int m = 0; m < NM; m++) model_step(m, sw, vs, rs);
    compare_all();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_pass   = 0;
    swap_fb  = 1'b0;
    vsync    = 1'b0;
    rst      = 1'b1;
    for (int m = 0; m < NM; m++) model_reset(m);

    // Reset values.
    do_reset();
    do_reset();
    chk("t1_render_addr", ra_o[0], 25'h010_0000);
    chk("t1_disp_addr", da_o[0], 25'h014_0000);
    chk("t1_swapped", sw_o[0], 1'b0);
    chk("t1_pending", sp_o[0], 1'b0);
    chk("t1_disp_addr_fb3", da_o[2], 25'h018_0000);

    // Vsync-locked double buffering: request at t0, vsync at t5.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    chk("t2_pending_t1", sp_o[0], 1'b1);
    for (int i = 2; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk($sformatf("t2_pending_t%0d", i), sp_o[0], 1'b1);
      chk($sformatf("t2_no_swap_t%0d", i), sw_o[0], 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0);
    chk("t2_swapped_t6", sw_o[0], 1'b1);
    chk("t2_pending_t6", sp_o[0], 1'b0);
    chk("t2_render_addr", ra_o[0], 25'h014_0000);
    chk("t2_disp_addr", da_o[0], 25'h010_0000);

    // Same-cycle swap and vsync, then a duplicate request while waiting.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    chk("t3_direct_commit", sw_o[0], 1'b1);
    chk("t3_never_pending", sp_o[0], 1'b0);
    pulses = 0;
    cycle(1'b1, 1'b0, 1'b0);
    pulses += int'(sw_o[0]);
    cycle(1'b1, 1'b0, 1'b0);
    pulses += int'(sw_o[0]);
    cycle(1'b0, 1'b1, 1'b0);
    pulses += int'(sw_o[0]);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      pulses += int'(sw_o[0]);
    end
    chk("t3_one_pulse", pulses, 1);

    // Triple buffering mailbox: three swaps without vsync.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      pulses += int'(sw_o[2]);
    end
    chk("t4_pulses", pulses, 3);
    chk("t4_drop_cnt", dc_o[2], 16'd2);
    chk("t4_disp_addr", da_o[2], 25'h018_0000);

    // Triple buffering with stall: second swap waits for vsync.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("t5_stalled", sp_o[3], 1'b1);
    chk("t5_no_commit", sw_o[3], 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t5_disp_addr", da_o[3], 25'h010_0000);
    chk("t5_commit", sw_o[3], 1'b1);
    chk("t5_drop_cnt", dc_o[3], 16'd0);

    // Reset while waiting for vsync.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("t6_swapped", sw_o[0], 1'b0);
    chk("t6_pending", sp_o[0], 1'b0);
    chk("t6_render_addr", ra_o[0], 25'h010_0000);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t6_vsync_swapped", sw_o[0], 1'b0);
    chk("t6_vsync_render", ra_o[0], 25'h010_0000);
    chk("t6_vsync_disp", da_o[0], 25'h014_0000);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
    end

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
    end
    chk("sat_drop_cnt", dc_o[2], 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
